// File: rtl/cmult_pkg.sv
// Shared constants and helpers for the cmult_rs complex multiplier.
// - CMULT_RS_LAT : input-to-output latency in enabled clock edges
// - full_w       : width of the full-precision internal product
// - rnd / sat_val / is_clip / rnd_sat : round-half-up and saturation on a
//   wide signed container, used per component by cmult_rs_rndsat
package cmult_pkg;

  localparam int CMULT_RS_LAT = 7;
  // Wide container for the round/saturate helpers; any legal product fits.
  localparam int MAXW = 128;

  typedef struct packed {
    logic                   clip;
    logic signed [MAXW-1:0] val;
  } rs_t;

  function automatic int full_w(input int aw, input int bw);
    return aw + bw + 2;
  endfunction

  // Round half up, then arithmetic shift. The container is far wider than
  // the product, so the bias add never wraps.
  function automatic logic signed [MAXW-1:0] rnd(input logic signed [MAXW-1:0] p,
                                                 input int shift);
    logic signed [MAXW-1:0] bias;
    if (shift == 0) return p;
    bias = '0;
    bias[shift-1] = 1'b1;
    return (p + bias) >>> shift;
  endfunction

  function automatic logic signed [MAXW-1:0] sat_hi(input int owidth);
    logic signed [MAXW-1:0] hi;
    hi = '0;
    hi[owidth-1] = 1'b1;
    return hi - MAXW'(1);
  endfunction

  function automatic logic is_clip(input logic signed [MAXW-1:0] r, input int owidth);
    logic signed [MAXW-1:0] hi;
    hi = sat_hi(owidth);
    return (r > hi) || (r < ~hi);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_val(input logic signed [MAXW-1:0] r,
                                                     input int owidth);
    logic signed [MAXW-1:0] hi;
    hi = sat_hi(owidth);
    if (r > hi) return hi;
    if (r < ~hi) return ~hi;
    return r;
  endfunction

  function automatic rs_t rnd_sat(input logic signed [MAXW-1:0] p, input int shift,
                                  input int owidth);
    rs_t res;
    res.clip = is_clip(rnd(p, shift), owidth);
    res.val  = sat_val(rnd(p, shift), owidth);
    return res;
  endfunction

endpackage

// File: rtl/cmult_rs_rndsat.sv
// One output component of cmult_rs: round (stage 6) then saturate (stage 7).
// Ports:
//   clk, rst, ce : clock, sync active-high reset, pipeline enable
//   p            : full-precision signed product, IW bits
//   val          : rounded/saturated result, OWIDTH bits
//   clip         : 1 when val was clipped
module cmult_rs_rndsat
  import cmult_pkg::*;
#(
  parameter int IW     = 36,
  parameter int SHIFT  = 17,
  parameter int OWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic signed [IW-1:0]     p,
  output logic signed [OWIDTH-1:0] val,
  output logic                     clip
);

  // One extra bit keeps the SHIFT=0 / bias-add cases exact.
  localparam int RW = IW + 1;

  logic signed [RW-1:0] r_p6;

  // Stage 6: round
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p6 <= '0;
    end else if (ce) begin
      r_p6 <= RW'(rnd(MAXW'(p), SHIFT));
    end
  end

  // Stage 7: saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      val  <= '0;
      clip <= 1'b0;
    end else if (ce) begin
      val  <= OWIDTH'(sat_val(MAXW'(r_p6), OWIDTH));
      clip <= is_clip(MAXW'(r_p6), OWIDTH);
    end
  end

endmodule

// File: rtl/cmult_rs.sv
// Pipelined complex multiplier P = A*B or A*conj(B), 3-multiplier form, with
// valid/tag sideband, round-half-up and saturation. Latency 7 enabled edges.
// Ports:
//   i_clk, i_rst, i_ce      : clock, sync active-high reset, pipeline enable
//   i_valid, i_conj, i_tag  : per-sample valid, conjugate select, sideband tag
//   i_are, i_aim            : A components, signed AWIDTH
//   i_bre, i_bim            : B components, signed BWIDTH
//   o_valid, o_tag          : delay-matched valid and tag
//   o_pre, o_pim            : rounded/saturated product, signed OWIDTH
//   o_sat                   : either component clipped (0 when o_valid=0)
module cmult_rs
  import cmult_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 17,
  parameter int TWIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic                     i_valid,
  input  logic                     i_conj,
  input  logic [TWIDTH-1:0]        i_tag,
  input  logic signed [AWIDTH-1:0] i_are,
  input  logic signed [AWIDTH-1:0] i_aim,
  input  logic signed [BWIDTH-1:0] i_bre,
  input  logic signed [BWIDTH-1:0] i_bim,
  output logic                     o_valid,
  output logic [TWIDTH-1:0]        o_tag,
  output logic signed [OWIDTH-1:0] o_pre,
  output logic signed [OWIDTH-1:0] o_pim,
  output logic                     o_sat
);

  localparam int PW = full_w(AWIDTH, BWIDTH);
  localparam int A1 = AWIDTH + 1;
  localparam int B1 = BWIDTH + 1;
  localparam int B2 = BWIDTH + 2;

  if (OWIDTH < 2 || OWIDTH > PW) begin : g_bad_owidth
    $fatal(1, "cmult_rs: OWIDTH must be in 2..AWIDTH+BWIDTH+2");
  end
  if (SHIFT < 0 || SHIFT > PW - 1) begin : g_bad_shift
    $fatal(1, "cmult_rs: SHIFT must be in 0..AWIDTH+BWIDTH+1");
  end
  if (TWIDTH < 1) begin : g_bad_twidth
    $fatal(1, "cmult_rs: TWIDTH must be >= 1");
  end
  if (PW + 1 >= MAXW) begin : g_bad_width
    $fatal(1, "cmult_rs: AWIDTH+BWIDTH too large for rounding container");
  end

  logic signed [B1-1:0]     bim_x;
  logic signed [AWIDTH-1:0] are_p1, aim_p1, are_p2, aim_p2, are_p3, aim_p3;
  logic signed [BWIDTH-1:0] bre_p1;
  logic signed [B1-1:0]     bim_p1, bim_p2;
  logic signed [A1-1:0]     dar_p2;
  logic signed [B2-1:0]     sb_p2, ab_p2, sb_p3, ab_p3;
  logic signed [PW-1:0]     com_p3, com_p4, mre_p4, mim_p4, pre_p5, pim_p5;
  logic [CMULT_RS_LAT-1:0]  vld_sr;
  logic [TWIDTH-1:0]        tag_sr [CMULT_RS_LAT];
  logic                     clip_re, clip_im;

  // Widen before negating so -(-2^(BWIDTH-1)) is representable.
  assign bim_x = {i_bim[BWIDTH-1], i_bim};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      are_p1 <= '0; aim_p1 <= '0; bre_p1 <= '0; bim_p1 <= '0;
      dar_p2 <= '0; sb_p2  <= '0; ab_p2  <= '0;
      are_p2 <= '0; aim_p2 <= '0; bim_p2 <= '0;
      com_p3 <= '0; sb_p3  <= '0; ab_p3  <= '0; are_p3 <= '0; aim_p3 <= '0;
      com_p4 <= '0; mre_p4 <= '0; mim_p4 <= '0;
      pre_p5 <= '0; pim_p5 <= '0;
    end else if (i_ce) begin
      // Stage 1: register inputs, fold conjugate into effective B imag
      are_p1 <= i_are;
      aim_p1 <= i_aim;
      bre_p1 <= i_bre;
      bim_p1 <= i_conj ? -bim_x : bim_x;
      // Stage 2: pre-adders
      dar_p2 <= A1'(are_p1) - A1'(aim_p1);
      sb_p2  <= B2'(bre_p1) - B2'(bim_p1);
      ab_p2  <= B2'(bre_p1) + B2'(bim_p1);
      are_p2 <= are_p1;
      aim_p2 <= aim_p1;
      bim_p2 <= bim_p1;
      // Stage 3: shared product (are-aim)*bim
      com_p3 <= PW'(dar_p2) * PW'(bim_p2);
      sb_p3  <= sb_p2;
      ab_p3  <= ab_p2;
      are_p3 <= are_p2;
      aim_p3 <= aim_p2;
      // Stage 4: per-component products
      mre_p4 <= PW'(sb_p3) * PW'(are_p3);
      mim_p4 <= PW'(ab_p3) * PW'(aim_p3);
      com_p4 <= com_p3;
      // Stage 5: final sums; true result always fits PW bits
      pre_p5 <= mre_p4 + com_p4;
      pim_p5 <= mim_p4 + com_p4;
    end
  end

  // Sideband delay line matched to all seven stages
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_sr <= '0;
      for (int i = 0; i < CMULT_RS_LAT; i++) tag_sr[i] <= '0;
    end else if (i_ce) begin
      vld_sr    <= {vld_sr[CMULT_RS_LAT-2:0], i_valid};
      tag_sr[0] <= i_tag;
      for (int i = 1; i < CMULT_RS_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  // Stages 6-7: round and saturate per component
  cmult_rs_rndsat #(.IW(PW), .SHIFT(SHIFT), .OWIDTH(OWIDTH)) u_rs_re (
    .clk(i_clk), .rst(i_rst), .ce(i_ce), .p(pre_p5), .val(o_pre), .clip(clip_re)
  );
  cmult_rs_rndsat #(.IW(PW), .SHIFT(SHIFT), .OWIDTH(OWIDTH)) u_rs_im (
    .clk(i_clk), .rst(i_rst), .ce(i_ce), .p(pim_p5), .val(o_pim), .clip(clip_im)
  );

  assign o_valid = vld_sr[CMULT_RS_LAT-1];
  assign o_tag   = tag_sr[CMULT_RS_LAT-1];
  assign o_sat   = vld_sr[CMULT_RS_LAT-1] & (clip_re | clip_im);

endmodule

// File: tb/tb_cmult_rs.sv
// Bench for cmult_rs: three instances (SHIFT/OWIDTH = 0/36, 17/16, 2/8) share
// one stimulus stream. A cycle model built from the direct complex-product
// formula predicts every output; directed steps add hand-computed checks.
module tb_cmult_rs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, ce = 1'b0, valid = 1'b0, conj = 1'b0;
  logic [3:0] tag = '0;
  logic signed [15:0] are = '0, aim = '0;
  logic signed [17:0] bre = '0, bim = '0;

  logic [2:0] ov, os;
  logic [3:0] ot [3];
  logic signed [35:0] pre0, pim0;
  logic signed [15:0] pre1, pim1;
  logic signed [7:0]  pre2, pim2;
  logic signed [63:0] op [3], oi [3];

  int total = 0, bad = 0;

  localparam int SH [3] = '{0, 17, 2};
  localparam int OW [3] = '{36, 16, 8};

  cmult_rs #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(36), .SHIFT(0), .TWIDTH(4)) u0 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_conj(conj), .i_tag(tag),
    .i_are(are), .i_aim(aim), .i_bre(bre), .i_bim(bim),
    .o_valid(ov[0]), .o_tag(ot[0]), .o_pre(pre0), .o_pim(pim0), .o_sat(os[0]));
  cmult_rs #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(16), .SHIFT(17), .TWIDTH(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_conj(conj), .i_tag(tag),
    .i_are(are), .i_aim(aim), .i_bre(bre), .i_bim(bim),
    .o_valid(ov[1]), .o_tag(ot[1]), .o_pre(pre1), .o_pim(pim1), .o_sat(os[1]));
  cmult_rs #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(8), .SHIFT(2), .TWIDTH(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_conj(conj), .i_tag(tag),
    .i_are(are), .i_aim(aim), .i_bre(bre), .i_bim(bim),
    .o_valid(ov[2]), .o_tag(ot[2]), .o_pre(pre2), .o_pim(pim2), .o_sat(os[2]));

  always_comb begin
    op[0] = pre0; op[1] = pre1; op[2] = pre2;
    oi[0] = pim0; oi[1] = pim1; oi[2] = pim2;
  end

  // Cycle model: slot 6 is what the outputs should show
  bit         m_vld [7];
  logic [3:0] m_tag [7];
  longint     m_re  [7][3];
  longint     m_im  [7][3];
  bit         m_sat [7][3];

  task automatic chk(input string nm, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  function automatic longint rs(input longint p, input int sh, input int ow, output bit clip);
    longint r, hi, lo;
    r  = (sh == 0) ? p : ((p + (longint'(1) <<< (sh - 1))) >>> sh);
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    clip = (r > hi) || (r < lo);
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 7; i++) begin
      m_vld[i] = 0; m_tag[i] = '0;
      for (int k = 0; k < 3; k++) begin m_re[i][k] = 0; m_im[i][k] = 0; m_sat[i][k] = 0; end
    end
  endtask

  task automatic model_push(input bit v, input bit cj, input logic [3:0] tg,
                            input longint ar, input longint ai, input longint br, input longint bi);
    longint pr, pi;
    bit c1, c2;
    for (int i = 6; i > 0; i--) begin
      m_vld[i] = m_vld[i-1]; m_tag[i] = m_tag[i-1];
      for (int k = 0; k < 3; k++) begin
        m_re[i][k] = m_re[i-1][k]; m_im[i][k] = m_im[i-1][k]; m_sat[i][k] = m_sat[i-1][k];
      end
    end
    pr = cj ? ar * br + ai * bi : ar * br - ai * bi;
    pi = cj ? ai * br - ar * bi : ai * br + ar * bi;
    m_vld[0] = v; m_tag[0] = tg;
    for (int k = 0; k < 3; k++) begin
      m_re[0][k]  = rs(pr, SH[k], OW[k], c1);
      m_im[0][k]  = rs(pi, SH[k], OW[k], c2);
      m_sat[0][k] = c1 | c2;
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), ov[k], m_vld[6]);
      if (m_vld[6]) begin
        chk($sformatf("tag%0d", k), ot[k], m_tag[6]);
        chk($sformatf("pre%0d", k), op[k], m_re[6][k]);
        chk($sformatf("pim%0d", k), oi[k], m_im[6][k]);
        chk($sformatf("sat%0d", k), os[k], m_sat[6][k]);
      end else begin
        chk($sformatf("sat_idle%0d", k), os[k], 0);
      end
    end
  endtask

  task automatic step(input bit c, input bit v, input bit cj, input logic [3:0] tg,
                      input longint ar, input longint ai, input longint br, input longint bi);
    ce = c; valid = v; conj = cj; tag = tg;
    are = 16'(ar); aim = 16'(ai); bre = 18'(br); bim = 18'(bi);
    @(posedge clk);
    if (rst) model_clear();
    else if (c) model_push(v, cj, tg, ar, ai, br, bi);
    #1;
    check_outs();
  endtask

  task automatic idle(input int n, input bit c);
    for (int i = 0; i < n; i++) step(c, 0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_valid%0d", nm, k), ov[k], 0);
      chk($sformatf("%s_sat%0d", nm, k), os[k], 0);
      chk($sformatf("%s_tag%0d", nm, k), ot[k], 0);
      chk($sformatf("%s_pre%0d", nm, k), op[k], 0);
      chk($sformatf("%s_pim%0d", nm, k), oi[k], 0);
    end
  endtask

  initial begin
    logic signed [15:0] ra, rb;
    logic signed [17:0] rc, rd;
    model_clear();

    // Reset state
    rst = 1'b1;
    idle(2, 1);
    rst = 1'b0;
    chk_all_zero("reset");

    // A=(3,4), B=(5,-2), conj=0 -> (23,14), exactly 7 edges
    step(1, 1, 0, 4'd5, 3, 4, 5, -2);
    idle(5, 1);
    chk("lat6_valid", ov[0], 0);
    idle(1, 1);
    chk("lat7_valid", ov[0], 1);
    chk("mul_pre", pre0, 23);
    chk("mul_pim", pim0, 14);
    chk("mul_sat", os[0], 0);
    chk("mul_tag", ot[0], 5);

    // conj=1 -> (7,26), with a stall in the middle
    step(1, 1, 1, 4'd6, 3, 4, 5, -2);
    idle(3, 1);
    idle(4, 0);
    idle(2, 1);
    chk("conj_lat6_valid", ov[0], 0);
    idle(1, 1);
    chk("conj_pre", pre0, 7);
    chk("conj_pim", pim0, 26);
    chk("conj_tag", ot[0], 6);

    // Extreme inputs: no internal wrap
    step(1, 1, 0, 4'd1, -32768, -32768, -131072, -131072);
    step(1, 1, 1, 4'd2, -32768, -32768, -131072, -131072);
    idle(5, 1);
    chk("big_pre0", pre0, 0);
    chk("big_pim0", pim0, 64'sd8589934592);
    chk("big_sat0", os[0], 0);
    chk("big_pre1", pre1, 0);
    chk("big_pim1", pim1, 32767);
    chk("big_sat1", os[1], 1);
    idle(1, 1);
    chk("bigc_pre0", pre0, 64'sd8589934592);
    chk("bigc_pim0", pim0, 0);
    chk("bigc_pre1", pre1, 32767);
    chk("bigc_pim1", pim1, 0);
    chk("bigc_sat1", os[1], 1);

    // SHIFT=2, OWIDTH=8: pre=6 -> 2, pre=-6 -> -1, pre=600 -> 127 clipped
    step(1, 1, 0, 4'd3, 3, 0, 2, 0);
    step(1, 1, 0, 4'd4, -3, 0, 2, 0);
    step(1, 1, 0, 4'd7, 30, 0, 20, 0);
    idle(4, 1);
    chk("rnd_pos", pre2, 2);
    chk("rnd_pos_sat", os[2], 0);
    idle(1, 1);
    chk("rnd_neg", pre2, -1);
    chk("rnd_neg_sat", os[2], 0);
    idle(1, 1);
    chk("rnd_clip", pre2, 127);
    chk("rnd_clip_sat", os[2], 1);
    idle(4, 1);

    // Conj toggling every sample, no dead cycles
    for (int i = 0; i < 20; i++) step(1, 1, i[0], 4'(i), 3, 4, 5, -2);
    idle(7, 1);

    // Random stream with pseudo-random stalls
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 18'($urandom); rd = 18'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
           4'(i), ra, rb, rc, rd);
    end
    idle(7, 1);

    // Reset with 5 samples in flight, asserted while stalled
    for (int i = 0; i < 5; i++) step(1, 1, 0, 4'(i + 9), 100 + i, -7, 300, 41);
    rst = 1'b1;
    idle(1, 0);
    rst = 1'b0;
    chk_all_zero("midrst");
    idle(8, 1);
    step(1, 1, 0, 4'd12, 3, 4, 5, -2);
    idle(5, 1);
    chk("post_rst_lat6", ov[0], 0);
    idle(2, 0);
    chk("post_rst_stall", ov[0], 0);
    idle(1, 1);
    chk("post_rst_lat7", ov[0], 1);
    chk("post_rst_pre", pre0, 23);
    chk("post_rst_tag", ot[0], 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
